fr2cur_sweep_sched: RTL



---
 rtl/fr2cur_pkg.sv | 17 +
 rtl/fr2cur_tag_pipe.sv | 34 +++
 rtl/fr2cur_sweep_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fr2cur_pkg.sv
// Shared types for the firing-rate-to-current sweep scheduler.
package fr2cur_pkg;
  localparam int FLOAT_W  = 32;
  localparam int CUR_W    = 32;
  localparam int CH_W_MAX = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [CH_W_MAX-1:0] ch;
  } tag_t;
endpackage

// File: rtl/fr2cur_tag_pipe.sv
// Latency-matched tag delay line; empty means nothing remains after this edge.
module fr2cur_tag_pipe
  import fr2cur_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t issue,
  output tag_t retire,
  output logic empty
);
  tag_t stage [PIPE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= issue;
      for (int i = 1; i < PIPE_LAT; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign retire = stage[PIPE_LAT-1];

  // the output stage drains at this edge, so only upstream stages count
  always_comb begin
    empty = ~issue.valid;
    for (int i = 0; i < PIPE_LAT - 1; i++)
      empty = empty & ~stage[i].valid;
  end
endmodule

// File: rtl/fr2cur_sweep_sched.sv
// Sweeps enabled channels through one shared rate-to-current datapath.
// Optional FR2CUR_CLAMP_NEG_EN: negative currents are written back as 0.
module fr2cur_sweep_sched
  import fr2cur_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic                     neuron_clk,
  input  logic                     reset_global,
  input  logic                     start,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic [FLOAT_W*N_CH-1:0]  f_fr_flat,
  output logic [FLOAT_W-1:0]       dp_fr,
  input  logic [CUR_W-1:0]         dp_current,
  output logic [CUR_W*N_CH-1:0]    i_current_flat,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);
  localparam int CH_W = $clog2(N_CH);

  state_t                    state, state_d;
  logic [FLOAT_W*N_CH-1:0]   snap;
  logic [N_CH-1:0]           mask, onehot, rem;
  logic [CH_W-1:0]           ch_sel;
  logic [FLOAT_W-1:0]        snap_sel;
  logic                      done_d;
  logic [CUR_W-1:0]          wb_val;
  tag_t                      push, retire;
  logic                      empty;

  always_comb begin
    ch_sel = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (mask[k]) ch_sel = CH_W'(k);
  end

  assign onehot = N_CH'(1) << ch_sel;
  assign rem    = mask & ~onehot;

  always_comb begin
    snap_sel = '0;
    for (int k = 0; k < N_CH; k++)
      if (ch_sel == CH_W'(k)) snap_sel = snap[k*FLOAT_W +: FLOAT_W];
  end

  always_comb begin
    state_d    = state;
    done_d     = 1'b0;
    dp_fr      = '0;
    push       = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (|ch_enable) state_d = S_ISSUE;
          else            done_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        dp_fr      = snap_sel;
        push.valid = 1'b1;
        push.ch    = CH_W_MAX'(ch_sel);
        if (rem == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge neuron_clk or posedge reset_global) begin
    if (reset_global) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_d;
      done    <= done_d;
      overrun <= start & busy;
    end
  end

  always_ff @(posedge neuron_clk or posedge reset_global) begin
    if (reset_global) begin
      snap <= '0;
      mask <= '0;
    end else if (state == S_IDLE && start) begin
      snap <= f_fr_flat;
      mask <= ch_enable;
    end else if (state == S_ISSUE) begin
      mask <= rem;
    end
  end

  fr2cur_tag_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tag_pipe (
    .clk    (neuron_clk),
    .rst    (reset_global),
    .issue  (push),
    .retire (retire),
    .empty  (empty)
  );

`ifdef FR2CUR_CLAMP_NEG_EN
  assign wb_val = dp_current[CUR_W-1] ? '0 : dp_current;
`else
  assign wb_val = dp_current;
`endif

  always_ff @(posedge neuron_clk or posedge reset_global) begin
    if (reset_global) begin
      i_current_flat <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++)
        if (retire.valid && retire.ch == CH_W_MAX'(k))
          i_current_flat[k*CUR_W +: CUR_W] <= wb_val;
    end
  end
endmodule
